melody_sequencer: RTL and testbench

//  Note sequencer directly upstream of the square-wave tone generator. Holds a small writable

---
 rtl/melody_sequencer_if.sv | 30 +++
 rtl/melody_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_melody_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/melody_sequencer_if.sv
// Control/status bundle between the melody sequencer and its host logic.
// The master side writes the note table and issues start/stop; the slave
// side (the sequencer) returns the tone period, gate and status.
interface melody_sequencer_if #(
   parameter int ADDR_W = 4
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_period;
   logic [15:0]       wr_dur;
   logic [ADDR_W:0]   num_notes;
   logic              loop;
   logic              start;
   logic              stop;
   logic [31:0]       period;
   logic              gate;
   logic [ADDR_W-1:0] note_idx;
   logic              busy;
   logic              done;

   modport master (
      output wr_en, wr_addr, wr_period, wr_dur, num_notes, loop, start, stop,
      input  period, gate, note_idx, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_period, wr_dur, num_notes, loop, start, stop,
      output period, gate, note_idx, busy, done
   );
endinterface

// File: rtl/melody_sequencer.sv
// Note sequencer feeding the square-wave tone generator. Plays a writable
// table of (half-period us, duration ms) entries in order, with an optional
// silent gap after each note, optional looping, and start/stop control.
module melody_sequencer #(
   parameter int CLK_F     = 200,
   parameter int MS_CYCLES = CLK_F * 1000,
   parameter int ADDR_W    = 4,
   parameter int GAP_MS    = 10
) (
   input  logic              CLK,
   input  logic              RESET_N,
   melody_sequencer_if.slave bus
);

   localparam int              DEPTH    = 1 << ADDR_W;
   localparam int              PRE_W    = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_CYCLES - 1);
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
   localparam logic [15:0]     GAP_LEN  = 16'(GAP_MS);
   localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W + 1)'(1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      PLAY,
      GAP
   } state_t;

   state_t            state;
   logic [47:0]       note_mem [DEPTH];
   logic [47:0]       rd_q;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W:0]   num_lat;
   logic              loop_lat;
   logic [PRE_W-1:0]  presc;
   logic [15:0]       ms_cnt;
   logic [31:0]       period_q;
   logic              gate_q;
   logic [ADDR_W-1:0] note_idx_q;
   logic              busy_q;
   logic              done_q;

   logic [31:0]       rd_period;
   logic [15:0]       rd_dur;
   logic              ms_tick;
   logic [15:0]       ms_next;
   logic [ADDR_W:0]   idx_inc;
   state_t            adv_state;
   logic [ADDR_W-1:0] adv_idx;
   logic              adv_end;

   assign rd_period = rd_q[47:16];
   assign rd_dur    = rd_q[15:0];
   assign ms_tick   = (presc == PRE_LAST);
   assign ms_next   = ms_cnt + 16'd1;
   assign idx_inc   = {1'b0, idx} + IDX_ONE;

   assign bus.period   = period_q;
   assign bus.gate     = gate_q;
   assign bus.note_idx = note_idx_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

   // Table storage: write port from the host, registered read issued in FETCH.
   // rd_q only moves in FETCH, so a write to the playing entry is seen on its next fetch.
   always_ff @(posedge CLK) begin
      if (bus.wr_en)
         note_mem[bus.wr_addr] <= {bus.wr_period, bus.wr_dur};
      if (state == FETCH)
         rd_q <= note_mem[idx];
   end

   // Where to go after an entry finishes or is skipped: next entry, wrap, or end.
   always_comb begin
      adv_state = FETCH;
      adv_idx   = idx_inc[ADDR_W-1:0];
      adv_end   = 1'b0;
      if (idx_inc >= num_lat) begin
         if (loop_lat) begin
            adv_idx = '0;
         end else begin
            adv_state = IDLE;
            adv_idx   = idx;
            adv_end   = 1'b1;
         end
      end
   end

   // Sequencer FSM with ms timing and registered outputs.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= IDLE;
         idx        <= '0;
         num_lat    <= '0;
         loop_lat   <= 1'b0;
         presc      <= '0;
         ms_cnt     <= '0;
         period_q   <= '0;
         gate_q     <= 1'b0;
         note_idx_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state != IDLE && bus.stop) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            gate_q   <= 1'b0;
            period_q <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (bus.start && !bus.stop) begin
                     if (bus.num_notes == '0) begin
                        done_q <= 1'b1;
                     end else begin
                        num_lat  <= bus.num_notes;
                        loop_lat <= bus.loop;
                        idx      <= '0;
                        busy_q   <= 1'b1;
                        state    <= FETCH;
                     end
                  end
               end
               FETCH: begin
                  state <= LOAD;
               end
               LOAD: begin
                  if (rd_dur == '0) begin
                     state <= adv_state;
                     idx   <= adv_idx;
                     if (adv_end) begin
                        busy_q   <= 1'b0;
                        gate_q   <= 1'b0;
                        period_q <= '0;
                        done_q   <= 1'b1;
                     end
                  end else begin
                     period_q   <= rd_period;
                     gate_q     <= (rd_period != '0);
                     note_idx_q <= idx;
                     presc      <= '0;
                     ms_cnt     <= '0;
                     state      <= PLAY;
                  end
               end
               PLAY: begin
                  if (ms_tick) begin
                     presc <= '0;
                     if (ms_next == rd_dur) begin
                        if (GAP_MS > 0) begin
                           gate_q <= 1'b0;
                           ms_cnt <= '0;
                           state  <= GAP;
                        end else begin
                           state <= adv_state;
                           idx   <= adv_idx;
                           if (adv_end) begin
                              busy_q   <= 1'b0;
                              gate_q   <= 1'b0;
                              period_q <= '0;
                              done_q   <= 1'b1;
                           end
                        end
                     end else begin
                        ms_cnt <= ms_next;
                     end
                  end else begin
                     presc <= presc + PRE_ONE;
                  end
               end
               GAP: begin
                  if (ms_tick) begin
                     presc <= '0;
                     if (ms_next == GAP_LEN) begin
                        state <= adv_state;
                        idx   <= adv_idx;
                        if (adv_end) begin
                           busy_q   <= 1'b0;
                           gate_q   <= 1'b0;
                           period_q <= '0;
                           done_q   <= 1'b1;
                        end
                     end else begin
                        ms_cnt <= ms_next;
                     end
                  end else begin
                     presc <= presc + PRE_ONE;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer with MS_CYCLES=10, ADDR_W=2, GAP_MS=1.
// Expected output segments are queued when a sequence is started and are
// checked cycle by cycle at the falling edge. Between two notes gate is low
// for the 10-cycle gap plus the FETCH and LOAD cycles of the next entry.
module tb_melody_sequencer;

   typedef struct {
      logic [31:0] period;
      logic        gate;
      int          idx;    // -1: note_idx not checked
      logic        busy;
      logic        done;
      int          len;
   } seg_t;

   typedef struct {
      logic [31:0] per;
      logic [15:0] dur;
      int          on_cycles;
      logic        gate_exp;
   } note_vec_t;

   logic CLK = 1'b0;
   logic RESET_N = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   seg_t seg_q[$];
   note_vec_t full_tab [4];

   melody_sequencer_if #(.ADDR_W(2)) bus ();

   melody_sequencer #(
      .CLK_F    (200),
      .MS_CYCLES(10),
      .ADDR_W   (2),
      .GAP_MS   (1)
   ) dut (
      .CLK    (CLK),
      .RESET_N(RESET_N),
      .bus    (bus)
   );

   always #5 CLK = ~CLK;

   task automatic exp_seg(input logic [31:0] p, input logic g, input int i,
                          input logic b, input logic d, input int n);
      seg_t s;
      s.period = p; s.gate = g; s.idx = i; s.busy = b; s.done = d; s.len = n;
      seg_q.push_back(s);
   endtask

   task automatic run_check(input string tag);
      seg_t s;
      int   bad;
      int   segn;
      logic [1:0] ie;
      segn = 0;
      while (seg_q.size() > 0) begin
         s = seg_q.pop_front();
         bad = 0;
         ie = 2'(s.idx);
         for (int c = 0; c < s.len; c++) begin
            @(negedge CLK);
            if (bad == 0 && (bus.period !== s.period || bus.gate !== s.gate ||
                bus.busy !== s.busy || bus.done !== s.done ||
                (s.idx >= 0 && bus.note_idx !== ie))) begin
               bad = 1;
               $display("FAIL %s seg%0d cyc%0d: got period=%0d gate=%0b idx=%0d busy=%0b done=%0b, want period=%0d gate=%0b idx=%0d busy=%0b done=%0b",
                        tag, segn, c, bus.period, bus.gate, bus.note_idx, bus.busy, bus.done,
                        s.period, s.gate, s.idx, s.busy, s.done);
            end
         end
         vectors++;
         if (bad != 0) miscompares++;
         segn++;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   task automatic wr(input int a, input logic [31:0] p, input logic [15:0] d);
      bus.wr_en = 1'b1; bus.wr_addr = 2'(a); bus.wr_period = p; bus.wr_dur = d;
      @(posedge CLK); #1;
      bus.wr_en = 1'b0;
   endtask

   task automatic do_start(input int n, input logic lp);
      bus.num_notes = 3'(n); bus.loop = lp; bus.start = 1'b1;
      @(posedge CLK); #1;
      bus.start = 1'b0;
   endtask

   task automatic do_stop();
      bus.stop = 1'b1;
      @(posedge CLK); #1;
      bus.stop = 1'b0;
   endtask

   initial begin
      full_tab[0] = '{per: 32'd40, dur: 16'd1, on_cycles: 10, gate_exp: 1'b1};
      full_tab[1] = '{per: 32'd0,  dur: 16'd2, on_cycles: 20, gate_exp: 1'b0};
      full_tab[2] = '{per: 32'd60, dur: 16'd1, on_cycles: 10, gate_exp: 1'b1};
      full_tab[3] = '{per: 32'd70, dur: 16'd1, on_cycles: 10, gate_exp: 1'b1};

      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_period = '0; bus.wr_dur = '0;
      bus.num_notes = '0; bus.loop = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;

      // Reset state
      @(negedge CLK);
      chk("rst_period", bus.period, 32'd0);
      chk("rst_gate", 32'(bus.gate), 32'd0);
      chk("rst_idx", 32'(bus.note_idx), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);

      // Two notes, no loop
      wr(0, 32'd100, 16'd3);
      wr(1, 32'd250, 16'd2);
      @(negedge CLK);
      exp_seg(0, 0, -1, 1, 0, 2);
      exp_seg(100, 1, 0, 1, 0, 30);
      exp_seg(100, 0, 0, 1, 0, 12);
      exp_seg(250, 1, 1, 1, 0, 20);
      exp_seg(250, 0, 1, 1, 0, 10);
      exp_seg(0, 0, 1, 0, 1, 1);
      exp_seg(0, 0, 1, 0, 0, 2);
      do_start(2, 1'b0);
      run_check("two_notes");

      // Same table looping, then stop
      exp_seg(0, 0, -1, 1, 0, 2);
      exp_seg(100, 1, 0, 1, 0, 30);
      exp_seg(100, 0, 0, 1, 0, 12);
      exp_seg(250, 1, 1, 1, 0, 20);
      exp_seg(250, 0, 1, 1, 0, 12);
      exp_seg(100, 1, 0, 1, 0, 10);
      do_start(2, 1'b1);
      run_check("loop");
      exp_seg(0, 0, -1, 0, 0, 2);
      do_stop();
      run_check("loop_stop");

      // Rest, zero-duration skip, short note
      wr(0, 32'd0, 16'd2);
      wr(1, 32'd50, 16'd0);
      wr(2, 32'd80, 16'd1);
      @(negedge CLK);
      exp_seg(0, 0, -1, 1, 0, 2);
      exp_seg(0, 0, 0, 1, 0, 20);
      exp_seg(0, 0, 0, 1, 0, 10);
      exp_seg(0, 0, 0, 1, 0, 4);
      exp_seg(80, 1, 2, 1, 0, 10);
      exp_seg(80, 0, 2, 1, 0, 10);
      exp_seg(0, 0, 2, 0, 1, 1);
      exp_seg(0, 0, 2, 0, 0, 1);
      do_start(3, 1'b0);
      run_check("rest_skip");

      // num_notes == 0
      exp_seg(0, 0, -1, 0, 1, 1);
      exp_seg(0, 0, -1, 0, 0, 3);
      do_start(0, 1'b0);
      run_check("zero_notes");

      // stop and start together while idle: nothing starts
      exp_seg(0, 0, -1, 0, 0, 3);
      bus.stop = 1'b1;
      do_start(2, 1'b0);
      bus.stop = 1'b0;
      run_check("idle_stop_start");

      // Full table: every entry played, including a rest
      for (int i = 0; i < 4; i++) wr(i, full_tab[i].per, full_tab[i].dur);
      @(negedge CLK);
      exp_seg(0, 0, -1, 1, 0, 2);
      for (int i = 0; i < 4; i++) begin
         exp_seg(full_tab[i].per, full_tab[i].gate_exp, i, 1, 0, full_tab[i].on_cycles);
         exp_seg(full_tab[i].per, 0, i, 1, 0, (i < 3) ? 12 : 10);
      end
      exp_seg(0, 0, 3, 0, 1, 1);
      exp_seg(0, 0, 3, 0, 0, 1);
      do_start(4, 1'b0);
      run_check("full_table");

      // Ignored start, overwrite of the playing entry, stop beats start
      wr(0, 32'd100, 16'd3);
      wr(1, 32'd250, 16'd2);
      @(negedge CLK);
      exp_seg(0, 0, -1, 1, 0, 2);
      exp_seg(100, 1, 0, 1, 0, 5);
      do_start(2, 1'b0);
      run_check("busy_pre");
      bus.start = 1'b1;
      bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_period = 32'd999; bus.wr_dur = 16'd7;
      @(posedge CLK); #1;
      bus.start = 1'b0; bus.wr_en = 1'b0;
      exp_seg(100, 1, 0, 1, 0, 10);
      run_check("busy_ignore");
      exp_seg(0, 0, -1, 0, 0, 3);
      bus.start = 1'b1;
      do_stop();
      bus.start = 1'b0;
      run_check("stop_wins");
      exp_seg(0, 0, -1, 1, 0, 2);
      exp_seg(999, 1, 0, 1, 0, 5);
      do_start(2, 1'b0);
      run_check("rewritten");
      exp_seg(0, 0, -1, 0, 0, 1);
      do_stop();
      run_check("rewritten_stop");

      // Asynchronous reset mid-note, then replay from entry 0
      exp_seg(0, 0, -1, 1, 0, 2);
      exp_seg(999, 1, 0, 1, 0, 15);
      do_start(2, 1'b0);
      run_check("pre_reset");
      #2 RESET_N = 1'b0;
      #1;
      chk("arst_gate", 32'(bus.gate), 32'd0);
      chk("arst_period", bus.period, 32'd0);
      chk("arst_busy", 32'(bus.busy), 32'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
      @(negedge CLK);
      exp_seg(0, 0, 0, 1, 0, 2);
      exp_seg(999, 1, 0, 1, 0, 5);
      do_start(2, 1'b0);
      run_check("replay");
      exp_seg(0, 0, -1, 0, 0, 1);
      do_stop();
      run_check("replay_stop");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
